// File: rtl/conv_encoder_if.sv
// ---------------------------------------------------------------------------
// conv_encoder_if
// Symbol-level bus between a frame source and the convolutional encoder.
//
// Handshake: the source presents start_sig/data_sig alongside a one-cycle
// tick_sig strobe; the encoder samples them only on tick cycles. A frame is
// accepted only when ready_sig=1 (encoder idle) and a tick carries
// start_sig=1. The source then provides one data_sig bit per tick until
// FRAME_LEN bits have been consumed. code_sig is meaningful while
// code_valid_sig=1, and frame_done_sig pulses once at the end of each frame.
//
// Signals:
//   tick_sig        source -> encoder  symbol strobe
//   start_sig       source -> encoder  frame start request
//   data_sig        source -> encoder  information bit
//   code_sig[1:0]   encoder -> sink    code word, [1]=G0 bit, [0]=G1 bit
//   code_valid_sig  encoder -> sink    code word belongs to current frame
//   ready_sig       encoder -> source  encoder is idle
//   frame_done_sig  encoder -> sink    end-of-frame pulse
// ---------------------------------------------------------------------------
interface conv_encoder_if;
  logic       tick_sig;
  logic       start_sig;
  logic       data_sig;
  logic [1:0] code_sig;
  logic       code_valid_sig;
  logic       ready_sig;
  logic       frame_done_sig;

  modport master (
    output tick_sig, start_sig, data_sig,
    input  code_sig, code_valid_sig, ready_sig, frame_done_sig
  );

  modport slave (
    input  tick_sig, start_sig, data_sig,
    output code_sig, code_valid_sig, ready_sig, frame_done_sig
  );
endinterface

// File: rtl/conv_encoder.sv
// ---------------------------------------------------------------------------
// conv_encoder
// Rate-1/2 feed-forward convolutional encoder with zero-terminated frames.
// Each frame encodes FRAME_LEN information bits followed by K-1 zero tail
// bits, so every frame leaves the shift register all-zero.
//
// Ports:
//   clk_sig       clock, rising edge
//   reset_sig     asynchronous active-low reset
//   bus           conv_encoder_if.slave (tick/start/data in, code/status out)
//   state_dbg_o   current FSM state (0=IDLE, 1=ENCODE, 2=FLUSH)
//   sr_dbg_o      current memory register contents, bit 0 newest
// ---------------------------------------------------------------------------
module conv_encoder #(
  parameter int           K         = 3,
  parameter logic [K-1:0] G0        = 3'b111,
  parameter logic [K-1:0] G1        = 3'b101,
  parameter int           FRAME_LEN = 8
) (
  input  logic                clk_sig,
  input  logic                reset_sig,
  conv_encoder_if.slave       bus,
  output logic [1:0]          state_dbg_o,
  output logic [K-2:0]        sr_dbg_o
);

  localparam int CW = $clog2(FRAME_LEN + 1);
  localparam int TW = $clog2(K);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ENCODE = 2'd1,
    S_FLUSH  = 2'd2
  } state_t;

  state_t         state_q;
  logic [K-2:0]   sr_q;
  logic [CW-1:0]  cnt_q;
  logic [TW-1:0]  tail_q;
  logic [1:0]     code_q;
  logic           valid_q;
  logic           ready_q;
  logic           done_q;

  logic           u;
  logic [K-1:0]   window;
  logic [1:0]     code_d;
  logic [K-2:0]   sr_d;

  // Window is {u, sr[0], ..., sr[K-2]}: the newest register bit sits just
  // below the input, so the register is bit-reversed into the window.
  always_comb begin
    u      = (state_q == S_ENCODE) ? bus.data_sig : 1'b0;
    window = '0;
    window[K-1] = u;
    for (int i = 0; i < K - 1; i++) begin
      window[K-2-i] = sr_q[i];
    end
    code_d = {^(G0 & window), ^(G1 & window)};
    sr_d   = {sr_q[K-3:0], u};
  end

  always_ff @(posedge clk_sig or negedge reset_sig) begin
    if (!reset_sig) begin
      state_q <= S_IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      tail_q  <= '0;
      code_q  <= 2'b00;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      // frame_done is a single-clock pulse, independent of the tick rate.
      done_q <= 1'b0;
      if (bus.tick_sig) begin
        case (state_q)
          S_IDLE: begin
            // The first idle tick after a frame retires the last tail word.
            valid_q <= 1'b0;
            if (bus.start_sig) begin
              sr_q    <= '0;
              cnt_q   <= '0;
              tail_q  <= '0;
              ready_q <= 1'b0;
              state_q <= S_ENCODE;
            end
          end
          S_ENCODE: begin
            code_q  <= code_d;
            valid_q <= 1'b1;
            sr_q    <= sr_d;
            if (cnt_q == CW'(FRAME_LEN - 1)) begin
              cnt_q   <= '0;
              state_q <= S_FLUSH;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
          S_FLUSH: begin
            code_q <= code_d;
            sr_q   <= sr_d;
            if (tail_q == TW'(K - 2)) begin
              tail_q  <= '0;
              ready_q <= 1'b1;
              done_q  <= 1'b1;
              state_q <= S_IDLE;
            end else begin
              tail_q <= tail_q + TW'(1);
            end
          end
          default: begin
            ready_q <= 1'b1;
            state_q <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign bus.code_sig       = code_q;
  assign bus.code_valid_sig = valid_q;
  assign bus.ready_sig      = ready_q;
  assign bus.frame_done_sig = done_q;
  assign state_dbg_o        = state_q;
  assign sr_dbg_o           = sr_q;

endmodule

// File: tb/tb_conv_encoder.sv
// ---------------------------------------------------------------------------
// tb_conv_encoder
// Bench for conv_encoder with K=3, G0=111, G1=101 at three frame lengths
// (4, 8, 1). A cycle table drives the FRAME_LEN=4 instance; hand-written
// sequences cover the all-zero frame, slow ticks, asynchronous reset and
// the single-bit frame.
// ---------------------------------------------------------------------------
module tb_conv_encoder;

  // ---------------- clock / reset ----------------
  logic clk_sig;
  logic reset_sig;

  initial clk_sig = 1'b0;
  always #5 clk_sig = ~clk_sig;

  // ---------------- stimulus signals ----------------
  logic tick;
  logic data;
  logic start4;
  logic start8;
  logic start1;

  conv_encoder_if if4 ();
  conv_encoder_if if8 ();
  conv_encoder_if if1 ();

  assign if4.tick_sig  = tick;
  assign if4.data_sig  = data;
  assign if4.start_sig = start4;
  assign if8.tick_sig  = tick;
  assign if8.data_sig  = data;
  assign if8.start_sig = start8;
  assign if1.tick_sig  = tick;
  assign if1.data_sig  = data;
  assign if1.start_sig = start1;

  logic [1:0] state4, state8, state1;
  logic [1:0] sr4, sr8, sr1;

  conv_encoder #(.K(3), .G0(3'b111), .G1(3'b101), .FRAME_LEN(4)) dut4 (
    .clk_sig(clk_sig), .reset_sig(reset_sig), .bus(if4),
    .state_dbg_o(state4), .sr_dbg_o(sr4)
  );
  conv_encoder #(.K(3), .G0(3'b111), .G1(3'b101), .FRAME_LEN(8)) dut8 (
    .clk_sig(clk_sig), .reset_sig(reset_sig), .bus(if8),
    .state_dbg_o(state8), .sr_dbg_o(sr8)
  );
  conv_encoder #(.K(3), .G0(3'b111), .G1(3'b101), .FRAME_LEN(1)) dut1 (
    .clk_sig(clk_sig), .reset_sig(reset_sig), .bus(if1),
    .state_dbg_o(state1), .sr_dbg_o(sr1)
  );

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // {code[1:0], valid, ready, done}
  function automatic logic [7:0] out4();
    return {3'b000, if4.code_sig, if4.code_valid_sig, if4.ready_sig, if4.frame_done_sig};
  endfunction
  function automatic logic [7:0] out8();
    return {3'b000, if8.code_sig, if8.code_valid_sig, if8.ready_sig, if8.frame_done_sig};
  endfunction
  function automatic logic [7:0] out1();
    return {3'b000, if1.code_sig, if1.code_valid_sig, if1.ready_sig, if1.frame_done_sig};
  endfunction

  // ---------------- driver ----------------
  // Inputs change at the falling edge; outputs are sampled at the next
  // falling edge, after the rising edge has acted on them.
  task automatic step(input logic t, input logic s4, input logic s8,
                      input logic s1, input logic d);
    tick   = t;
    start4 = s4;
    start8 = s8;
    start1 = s1;
    data   = d;
    @(posedge clk_sig);
    @(negedge clk_sig);
  endtask

  // ---------------- cycle table for FRAME_LEN=4 ----------------
  typedef struct packed {
    logic       t;
    logic       s;
    logic       d;
    logic [1:0] code;
    logic       v;
    logic       r;
    logic       dn;
  } vec_t;

  localparam int NVEC = 21;
  vec_t vecs [NVEC];

  // Timeout guard: the sequence is fixed-length, this only trips on a hang.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    logic [1:0] slow_exp [6];
    logic [3:0] slow_bits;
    int         vcnt;

    //          t s d cd v r dn
    vecs[0]  = 8'b0_1_1_00_0_1_0;  // start without tick is ignored
    vecs[1]  = 8'b1_1_0_00_0_0_0;  // start tick: no code word yet
    vecs[2]  = 8'b1_1_1_11_1_0_0;  // u=1, start held and ignored
    vecs[3]  = 8'b0_0_1_11_1_0_0;  // no tick: hold
    vecs[4]  = 8'b0_1_0_11_1_0_0;  // no tick: hold
    vecs[5]  = 8'b1_1_0_10_1_0_0;  // u=0
    vecs[6]  = 8'b1_0_1_00_1_0_0;  // u=1
    vecs[7]  = 8'b1_1_1_01_1_0_0;  // u=1, last info bit
    vecs[8]  = 8'b0_1_1_01_1_0_0;  // no tick in FLUSH: hold
    vecs[9]  = 8'b1_1_1_01_1_0_0;  // tail 1 (data ignored)
    vecs[10] = 8'b1_1_0_11_1_1_1;  // tail 2, back to IDLE, done pulse
    vecs[11] = 8'b0_1_1_11_1_1_0;  // done drops, valid held until tick
    vecs[12] = 8'b1_1_0_11_0_0_0;  // idle tick with start: new frame
    vecs[13] = 8'b1_0_1_11_1_0_0;  // u=1 from cleared register
    vecs[14] = 8'b1_0_1_01_1_0_0;  // u=1
    vecs[15] = 8'b1_0_0_01_1_0_0;  // u=0
    vecs[16] = 8'b1_0_0_11_1_0_0;  // u=0, last info bit
    vecs[17] = 8'b1_0_0_00_1_0_0;  // tail 1
    vecs[18] = 8'b1_0_0_00_1_1_1;  // tail 2, done
    vecs[19] = 8'b1_0_0_00_0_1_0;  // idle tick clears valid
    vecs[20] = 8'b1_0_0_00_0_1_0;  // stays idle

    slow_exp[0] = 2'b11; slow_exp[1] = 2'b10; slow_exp[2] = 2'b00;
    slow_exp[3] = 2'b01; slow_exp[4] = 2'b01; slow_exp[5] = 2'b11;
    slow_bits   = 4'b1101;  // bit i is the i-th information bit: 1,0,1,1

    tick = 1'b0; data = 1'b0; start4 = 1'b0; start8 = 1'b0; start1 = 1'b0;
    reset_sig = 1'b0;
    repeat (2) @(negedge clk_sig);

    // ---- reset state ----
    check("reset_out4", out4(), 8'b000_00_0_1_0);
    check("reset_state4", {6'd0, state4}, 8'd0);
    check("reset_out8", out8(), 8'b000_00_0_1_0);
    check("reset_out1", out1(), 8'b000_00_0_1_0);
    reset_sig = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // ---- table: FRAME_LEN=4, start held, ticks gapped, back-to-back ----
    for (int i = 0; i < NVEC; i++) begin
      step(vecs[i].t, vecs[i].s, 1'b0, 1'b0, vecs[i].d);
      check($sformatf("vec[%0d]", i), out4(),
            {3'b000, vecs[i].code, vecs[i].v, vecs[i].r, vecs[i].dn});
    end
    check("sr4_after_table", {6'd0, sr4}, 8'd0);

    // ---- all-zero frame, FRAME_LEN=8: ten 00 words ----
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    check("zero_start", out8(), 8'b000_00_0_0_0);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      check($sformatf("zero_word[%0d]", i), out8(),
            (i == 9) ? 8'b000_00_1_1_1 : 8'b000_00_1_0_0);
    end
    check("zero_sr_final", {6'd0, sr8}, 8'd0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("zero_valid_clear", out8(), 8'b000_00_0_1_0);

    // ---- slow ticks: one tick every 4 clocks, data toggling in between ----
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (3) step(1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'($urandom_range(0, 1)));
    for (int k = 0; k < 6; k++) begin
      logic b;
      b = (k < 4) ? slow_bits[k] : 1'b0;
      step(1'b1, 1'b0, 1'b0, 1'b0, b);
      check($sformatf("slow_tick[%0d]", k), {6'd0, if4.code_sig}, {6'd0, slow_exp[k]});
      for (int c = 0; c < 3; c++) begin
        step(1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b0, ~b);
        check($sformatf("slow_hold[%0d.%0d]", k, c), {6'd0, if4.code_sig}, {6'd0, slow_exp[k]});
      end
    end
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("slow_end_idle", out4(), 8'b000_11_0_1_0);

    // ---- asynchronous reset during the third ENCODE tick ----
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    check("rst_pre_w0", out4(), 8'b000_11_1_0_0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("rst_pre_w1", out4(), 8'b000_10_1_0_0);
    tick = 1'b1; data = 1'b1;
    #2 reset_sig = 1'b0;
    #1;
    check("rst_async_out", out4(), 8'b000_00_0_1_0);
    check("rst_async_state", {6'd0, state4}, 8'd0);
    check("rst_async_sr", {6'd0, sr4}, 8'd0);
    @(posedge clk_sig);
    @(negedge clk_sig);
    check("rst_held_out", out4(), 8'b000_00_0_1_0);
    #2 reset_sig = 1'b1;
    @(negedge clk_sig);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    check("rst_no_autostart", out4(), 8'b000_00_0_1_0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    check("rst_fresh_w0", out4(), 8'b000_11_1_0_0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("rst_fresh_w1", out4(), 8'b000_10_1_0_0);

    // ---- FRAME_LEN=1, data 1: 11, 10, 11 ----
    vcnt = 0;
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    check("len1_start", out1(), 8'b000_00_0_0_0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    vcnt += int'(if1.code_valid_sig);
    check("len1_w0", out1(), 8'b000_11_1_0_0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    vcnt += int'(if1.code_valid_sig);
    check("len1_w1", out1(), 8'b000_10_1_0_0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    vcnt += int'(if1.code_valid_sig);
    check("len1_w2", out1(), 8'b000_11_1_1_1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    vcnt += int'(if1.code_valid_sig);
    check("len1_after", out1(), 8'b000_11_0_1_0);
    check("len1_valid_ticks", 8'(vcnt), 8'd3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/conv_encoder.md
CONV_ENCODER -- requirements
Module: conv_encoder

Interface
REQ-001 SHALL have parameter K, default 3, constraint length (3..9).
REQ-002 SHALL have parameter G0, default 3'b111, K-bit generator for the first code bit; bit K-1 taps the current input.
REQ-003 SHALL have parameter G1, default 3'b101, K-bit generator for the second code bit; same tap ordering as G0.
REQ-004 SHALL have parameter FRAME_LEN, default 8, number of information bits per frame (>=1).
REQ-005 SHALL have port clk_sig  input  1  single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset_sig  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port tick_sig  input  1  one-cycle symbol strobe; all state advancement occurs only on cycles where tick_sig=1.
REQ-008 SHALL have port start_sig  input  1  frame start request, sampled on tick.
REQ-009 SHALL have port data_sig  input  1  information bit, sampled on tick in ENCODE.
REQ-010 SHALL have port code_sig  output  2  registered code word; code_sig[1]=G0 output (transmitted first downstream), code_sig[0]=G1 output.
REQ-011 SHALL have port code_valid_sig  output  1  high while code_sig holds a word of the current frame.
REQ-012 SHALL have port ready_sig  output  1  high only in IDLE.
REQ-013 SHALL have port frame_done_sig  output  1  one-cycle pulse at frame end.

Function
REQ-014 SHALL implement FSM with states IDLE, ENCODE and FLUSH.
REQ-015 SHALL hold memory register sr of K-1 bits, with sr[0] newest; encode window is {u, sr[0], ..., sr[K-2]}, and window bit K-1 is u.
REQ-016 SHALL compute code bit j as the XOR reduction of (Gj AND window).
REQ-017 SHALL, in IDLE, on tick with start_sig=1, clear sr and the bit counter and go to ENCODE; no code word is produced on this tick.
REQ-018 SHALL ignore start_sig outside IDLE, and on cycles without a tick.
REQ-019 SHALL, in ENCODE, on each tick: set u=data_sig, load code_sig from the window, shift sr (sr[0]<=u), and increment the counter.
REQ-020 SHALL move from ENCODE to FLUSH on the tick consuming bit FRAME_LEN, and reset the counter.
REQ-021 SHALL, in FLUSH, on each tick: encode u=0 (tail bit) the same way; after K-1 tail ticks go to IDLE.
REQ-022 SHALL make frame output exactly FRAME_LEN+K-1 code words, leaving sr all-zero at the end (zero-terminated trellis).
REQ-023 SHALL have latency of code_sig = 1 clock after the consuming tick; code_sig holds its value until the next consuming tick.
REQ-024 SHALL set code_valid_sig high from the first ENCODE output until the tick that follows the last tail output; that tick clears it.
REQ-025 SHALL pulse frame_done_sig for one clock on the cycle after the last tail word is loaded.
REQ-026 SHALL hold all state when tick_sig=0, regardless of data_sig or start_sig.
REQ-027 SHALL size the counter at $clog2(FRAME_LEN+1) bits; it never exceeds FRAME_LEN and wraps to 0 on each state transition.
REQ-028 SHALL, when FRAME_LEN=1, encode one bit and then FLUSH.
REQ-029 SHALL, in IDLE, accept a start on the same tick on which FLUSH→IDLE completed only on the next tick; back-to-back frames therefore have exactly one IDLE tick between them.

Reset
REQ-030 SHALL, with reset_sig=0, immediately and asynchronously force: state=IDLE, sr=0, counter=0, code_sig=2'b00, code_valid_sig=0, frame_done_sig=0, ready_sig=1.
REQ-031 SHALL, on reset mid-frame, abandon the frame with no frame_done_sig; after release, start_sig is required to begin a new frame.
REQ-032 SHALL resume operation on the first tick at least one clock after reset_sig rises.

Verification
REQ-033 SHALL cover: K=3, G0=111, G1=101, FRAME_LEN=4, start then data 1,0,1,1 on ticks -> code_sig sequence 11,10,00,01, then tail 01,11; frame_done_sig pulses once.
REQ-034 SHALL cover: all-zero frame, FRAME_LEN=8 -> ten code words all 00, then final sr=0.
REQ-035 SHALL cover: ticks every 4 clocks, data_sig toggling between ticks -> outputs depend only on tick-sampled values, with code_sig stable for 4 clocks.
REQ-036 SHALL cover: reset_sig low asynchronously (between clock edges) during the third ENCODE tick -> all outputs 0 and ready_sig=1 at once; a later start yields fresh output starting 11 for data 1.
REQ-037 SHALL cover: start_sig held high during ENCODE/FLUSH -> no restart; after frame_done_sig, next frame begins one tick later.
REQ-038 SHALL cover: FRAME_LEN=1, data 1 -> code words 11,10,11, and code_valid_sig high for exactly three ticks.
